// File: rtl/mat_vec_mult_param.sv
// rtl/mat_vec_mult_param.sv - ROWS x COLS matrix-vector multiply engine with skewed MAC lanes
module mat_vec_mult_param #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(COLS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      start,
    input  logic                      signed_mode,
    input  logic                      accum,
    input  logic [ROWS-1:0]           a_wren,
    input  logic [DATA_WIDTH-1:0]     a_data,
    input  logic                      b_wren,
    input  logic [DATA_WIDTH-1:0]     b_data,
    output logic                      ready,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [ROWS*ACC_WIDTH-1:0] out
);

    localparam int CW = $clog2(COLS + 1);
    localparam int IW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TW = $clog2(ROWS + COLS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         cnt_q, cnt_d;
    logic                  sm_q;
    logic                  ready_q, ready_d;
    logic                  done_q;
    logic                  err_q;
    logic                  err_set;
    logic                  accept;
    logic                  last;
    logic                  b_pop;
    logic                  b_wr_ok;
    logic [CW-1:0]         b_cnt_q, b_cnt_d;
    logic [DATA_WIDTH-1:0] b_mem_q [COLS];
    logic [DATA_WIDTH-1:0] b_sh_q  [ROWS];
    logic [DATA_WIDTH-1:0] b_lane  [ROWS];
    logic [DATA_WIDTH-1:0] a_mem_q [ROWS][COLS];
    logic [DATA_WIDTH-1:0] a_head  [ROWS];
    logic [CW-1:0]         a_cnt_q [ROWS];
    logic [CW-1:0]         a_cnt_d [ROWS];
    logic                  a_wr_ok [ROWS];
    logic                  lane_act[ROWS];
    logic [ACC_WIDTH-1:0]  term    [ROWS];
    logic [ACC_WIDTH-1:0]  out_q   [ROWS];

    // Every run drains each FIFO completely from slot 0, so the head is the
    // slot after the ones already popped.
    function automatic logic [IW-1:0] head_idx(input logic [CW-1:0] count);
        logic [CW-1:0] popped;
        popped = CW'(COLS) - count;
        return IW'(popped);
    endfunction

    // Product of two operands, extended per mode; the 2*DATA_WIDTH low bits of
    // the product of extended operands are exact in both modes.
    function automatic logic [ACC_WIDTH-1:0] mac_term(input logic [DATA_WIDTH-1:0] a,
                                                      input logic [DATA_WIDTH-1:0] b,
                                                      input logic sm);
        logic [2*DATA_WIDTH-1:0] a_x;
        logic [2*DATA_WIDTH-1:0] b_x;
        logic [2*DATA_WIDTH-1:0] p;
        logic signed [2*DATA_WIDTH:0] p_s;
        a_x = {{DATA_WIDTH{sm & a[DATA_WIDTH-1]}}, a};
        b_x = {{DATA_WIDTH{sm & b[DATA_WIDTH-1]}}, b};
        p   = a_x * b_x;
        p_s = {sm & p[2*DATA_WIDTH-1], p};
        return ACC_WIDTH'(p_s);
    endfunction

    assign accept = (state_q == IDLE) && start && ready_q && !clr;
    assign last   = (state_q == RUN) && (cnt_q == TW'(ROWS + COLS - 2));
    assign b_pop  = (state_q == RUN) && (int'(cnt_q) < COLS);

    // Next-state logic: clr forces IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end
                end
                RUN: begin
                    if (last) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and run counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Lane operands: A heads, B skew taps, activity windows and products.
    always_comb begin
        b_lane[0] = b_mem_q[head_idx(b_cnt_q)];
        for (int r = 1; r < ROWS; r++) begin
            b_lane[r] = b_sh_q[r];
        end
        for (int r = 0; r < ROWS; r++) begin
            a_head[r]   = a_mem_q[r][head_idx(a_cnt_q[r])];
            lane_act[r] = (state_q == RUN) && (int'(cnt_q) >= r) &&
                          (int'(cnt_q) <= r + COLS - 1);
            term[r]     = mac_term(a_head[r], b_lane[r], sm_q);
        end
    end

    // Write acceptance, error detection, next FIFO fill levels and readiness.
    always_comb begin
        err_set = 1'b0;
        b_wr_ok = 1'b0;
        b_cnt_d = b_cnt_q;
        ready_d = (state_d == IDLE);
        if (b_wren) begin
            if (state_q == IDLE && b_cnt_q != CW'(COLS)) b_wr_ok = 1'b1;
            else                                         err_set = 1'b1;
        end
        if (clr)          b_cnt_d = '0;
        else if (b_wr_ok) b_cnt_d = b_cnt_q + 1'b1;
        else if (b_pop)   b_cnt_d = b_cnt_q - 1'b1;
        if (b_cnt_d != CW'(COLS)) ready_d = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            a_wr_ok[r] = 1'b0;
            a_cnt_d[r] = a_cnt_q[r];
            if (a_wren[r]) begin
                if (state_q == IDLE && a_cnt_q[r] != CW'(COLS)) a_wr_ok[r] = 1'b1;
                else                                            err_set    = 1'b1;
            end
            if (clr)              a_cnt_d[r] = '0;
            else if (a_wr_ok[r])  a_cnt_d[r] = a_cnt_q[r] + 1'b1;
            else if (lane_act[r]) a_cnt_d[r] = a_cnt_q[r] - 1'b1;
            if (a_cnt_d[r] != CW'(COLS)) ready_d = 1'b0;
        end
    end

    // FIFO storage: writes land at the current fill level.
    always_ff @(posedge clk) begin
        if (b_wr_ok && !clr) b_mem_q[b_cnt_q[IW-1:0]] <= b_data;
        for (int r = 0; r < ROWS; r++) begin
            if (a_wr_ok[r] && !clr) a_mem_q[r][a_cnt_q[r][IW-1:0]] <= a_data;
        end
    end

    // Fill levels, skew chain, accumulators and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_cnt_q <= '0;
            sm_q    <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                a_cnt_q[r] <= '0;
                b_sh_q[r]  <= '0;
                out_q[r]   <= '0;
            end
        end else begin
            b_cnt_q   <= b_cnt_d;
            ready_q   <= ready_d;
            done_q    <= last && !clr;
            err_q     <= clr ? 1'b0 : (err_q | err_set);
            b_sh_q[0] <= '0;
            if (accept) sm_q <= signed_mode;
            for (int r = 1; r < ROWS; r++) begin
                b_sh_q[r] <= b_lane[r-1];
            end
            for (int r = 0; r < ROWS; r++) begin
                a_cnt_q[r] <= a_cnt_d[r];
                if (clr || (accept && !accum)) out_q[r] <= '0;
                else if (lane_act[r])          out_q[r] <= out_q[r] + term[r];
            end
        end
    end

    // Flatten the lane results onto the output bus.
    always_comb begin
        out = '0;
        for (int r = 0; r < ROWS; r++) begin
            out[r*ACC_WIDTH +: ACC_WIDTH] = out_q[r];
        end
    end

    assign ready = ready_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_mat_vec_mult_param.sv
// tb/tb_mat_vec_mult_param.sv - self-checking bench for mat_vec_mult_param
module tb_mat_vec_mult_param;

    localparam int R  = 8;
    localparam int C  = 8;
    localparam int DW = 8;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          start;
    logic          signed_mode;
    logic          accum;
    logic [R-1:0]  a_wren;
    logic [DW-1:0] a_data;
    logic          b_wren;
    logic [DW-1:0] b_data;
    logic          ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [R*AW-1:0] out;

    mat_vec_mult_param #(.ROWS(R), .COLS(C), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .start(start),
        .signed_mode(signed_mode), .accum(accum),
        .a_wren(a_wren), .a_data(a_data), .b_wren(b_wren), .b_data(b_data),
        .ready(ready), .busy(busy), .done(done), .err(err), .out(out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ma [R][C];
    logic [DW-1:0] mb [C];
    logic [AW-1:0] expv [R];

    function automatic logic [AW-1:0] lane(input int r);
        return out[r*AW +: AW];
    endfunction

    // Reference: plain arithmetic on the stored matrix and vector.
    task automatic model(input bit sm, input bit acc);
        longint s, va, vb;
        for (int r = 0; r < R; r++) begin
            s = acc ? longint'(expv[r]) : 0;
            for (int k = 0; k < C; k++) begin
                va = sm ? longint'($signed(ma[r][k])) : longint'(ma[r][k]);
                vb = sm ? longint'($signed(mb[k]))    : longint'(mb[k]);
                s  = s + va * vb;
            end
            expv[r] = s[AW-1:0];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0; start = 1'b0; signed_mode = 1'b0; accum = 1'b0;
        a_wren = '0; a_data = '0; b_wren = 1'b0; b_data = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < R; r++) expv[r] = '0;
    endtask

    task automatic set_pattern();
        for (int r = 0; r < R; r++)
            for (int k = 0; k < C; k++) ma[r][k] = DW'(r + 1);
        for (int k = 0; k < C; k++) mb[k] = DW'(k + 1);
    endtask

    task automatic set_const(input logic [DW-1:0] av, input logic [DW-1:0] bv);
        for (int r = 0; r < R; r++)
            for (int k = 0; k < C; k++) ma[r][k] = av;
        for (int k = 0; k < C; k++) mb[k] = bv;
    endtask

    task automatic set_random();
        for (int r = 0; r < R; r++)
            for (int k = 0; k < C; k++) ma[r][k] = DW'($urandom_range(0, 255));
        for (int k = 0; k < C; k++) mb[k] = DW'($urandom_range(0, 255));
    endtask

    // Writes ma/mb into the FIFOs; skip_row (if >= 0) misses its last element.
    task automatic load(input int skip_row);
        for (int k = 0; k < C; k++) begin
            for (int r = 0; r < R; r++) begin
                @(negedge clk);
                a_wren = '0;
                if (!(r == skip_row && k == C - 1)) a_wren[r] = 1'b1;
                a_data = ma[r][k];
                b_wren = (r == 0);
                b_data = mb[k];
            end
        end
        @(negedge clk);
        a_wren = '0;
        b_wren = 1'b0;
    endtask

    task automatic check_lanes(input string name);
        for (int r = 0; r < R; r++) begin
            checks++;
            if (lane(r) !== expv[r]) begin
                errors++;
                $display("FAIL %s lane %0d: got %0h expected %0h", name, r, lane(r), expv[r]);
            end
        end
    endtask

    // Accept a run, check handshake timing and results against the model.
    task automatic run_check(input string name, input bit sm, input bit acc);
        int cyc, nb;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before: got %b expected 1", name, ready);
        end
        model(sm, acc);
        start = 1'b1; signed_mode = sm; accum = acc;
        @(negedge clk);
        start = 1'b0; signed_mode = 1'b0; accum = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_drop: got %b expected 0", name, ready);
        end
        cyc = 1; nb = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy === 1'b1) nb++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != R + C) begin
            errors++;
            $display("FAIL %s done_latency: got %0d expected %0d", name, cyc, R + C);
        end
        checks++;
        if (nb != R + C - 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d (busy at done %b) expected %0d", name, nb, busy, R + C - 1);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: got %b expected 0", name, done);
        end
        check_lanes(name);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ready, busy, done, err} !== 4'b0000 || out !== '0) begin
            errors++;
            $display("FAIL reset: got rdy/busy/done/err %b%b%b%b out %0h expected 0000 out 0",
                     ready, busy, done, err, out);
        end
    endtask

    task automatic test_unsigned_pattern();
        set_pattern();
        load(-1);
        run_check("pattern", 1'b0, 1'b0);
        for (int r = 0; r < R; r++) begin
            checks++;
            if (lane(r) !== AW'(36 * (r + 1))) begin
                errors++;
                $display("FAIL pattern_const lane %0d: got %0d expected %0d", r, lane(r), 36 * (r + 1));
            end
        end
    endtask

    task automatic test_accum();
        set_pattern();
        load(-1);
        run_check("accum", 1'b0, 1'b1);
        for (int r = 0; r < R; r++) begin
            checks++;
            if (lane(r) !== AW'(72 * (r + 1))) begin
                errors++;
                $display("FAIL accum_const lane %0d: got %0d expected %0d", r, lane(r), 72 * (r + 1));
            end
        end
    endtask

    task automatic test_signed();
        set_const(8'hFF, 8'h02);
        load(-1);
        run_check("signed", 1'b1, 1'b0);
        checks++;
        if (lane(R - 1) !== 19'h7FFF0) begin
            errors++;
            $display("FAIL signed_const: got %0h expected 7fff0", lane(R - 1));
        end
    endtask

    task automatic test_max_unsigned();
        set_const(8'hFF, 8'hFF);
        load(-1);
        run_check("max_unsigned", 1'b0, 1'b0);
        checks++;
        if (lane(0) !== 19'd520200) begin
            errors++;
            $display("FAIL max_unsigned_const: got %0d expected 520200", lane(0));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            set_random();
            load(-1);
            run_check($sformatf("random%0d", i), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_busy_write();
        int cyc;
        do_reset();
        set_random();
        load(-1);
        model(1'b0, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a_wren = '1; a_data = 8'h55; b_wren = 1'b1; b_data = 8'h55;
        @(negedge clk);
        a_wren = '0; b_wren = 1'b0;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL busy_write_err: got %b expected 1", err);
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL busy_write_done: got %b expected 1", done);
        end
        check_lanes("busy_write");
    endtask

    task automatic test_partial_row();
        do_reset();
        set_random();
        load(3);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL partial_ready: got %b expected 0", ready);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL partial_start_ignored: got busy %b ready %b err %b expected 0 0 0", busy, ready, err);
        end
        a_wren = 8'h08; a_data = ma[3][C-1];
        @(negedge clk);
        a_wren = '0;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL partial_ready_after_fill: got %b expected 1", ready);
        end
        run_check("partial", 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        do_reset();
        set_random();
        load(-1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL overflow_err_before: got %b expected 0", err);
        end
        a_wren = 8'h04; a_data = ~ma[2][0];
        @(negedge clk);
        a_wren = '0;
        checks++;
        if (err !== 1'b1 || ready !== 1'b1) begin
            errors++;
            $display("FAIL overflow_err: got err %b ready %b expected 1 1", err, ready);
        end
        run_check("overflow", 1'b1, 1'b0);
    endtask

    task automatic test_clr_abort();
        int seen;
        do_reset();
        set_pattern();
        load(-1);
        a_wren = 8'h01; a_data = 8'h77;
        @(negedge clk);
        a_wren = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || lane(0) !== 19'd15 || err !== 1'b1) begin
            errors++;
            $display("FAIL clr_precheck: got busy %b lane0 %0d err %b expected 1 15 1", busy, lane(0), err);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        for (int r = 0; r < R; r++) expv[r] = '0;
        checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || err !== 1'b0 || done !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL clr_abort: got busy %b ready %b err %b done %b out %0h expected 0 0 0 0 0",
                     busy, ready, err, done, out);
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1 || busy === 1'b1) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0 || out !== '0) begin
            errors++;
            $display("FAIL clr_no_done: got %0d busy/done cycles out %0h expected 0 and 0", seen, out);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_pattern();
        test_accum();
        test_signed();
        test_max_unsigned();
        test_random();
        test_busy_write();
        test_partial_row();
        test_overflow();
        test_clr_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mat_vec_mult_param.md
# mat_vec_mult_param

Parametrised matrix-vector multiply engine: loads a ROWS x COLS matrix A and a COLS-element vector B into internal per-row FIFOs, then computes out[r] = sum_k A[r][k]*B[k] on ROWS MAC lanes fed with a diagonal (skewed) schedule. It is the general successor to the fixed 8x8 unsigned multiplier, adding:
- explicit start/busy/done handshake
- signed mode and accumulate mode
- error flagging
- abortable clear

## Interface
- ROWS, 8, number of matrix rows / MAC lanes (>=1)
- COLS, 8, matrix columns = vector length = FIFO depth (>=1)
- DATA_WIDTH, 8, width of each A and B element
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(COLS), accumulator/result width per row
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- clr  input  1  synchronous flush: empties FIFOs, zeros results, clears err, aborts a run
- start  input  1  request a run; accepted only when ready=1
- signed_mode  input  1  sampled with start: 1 = two's-complement operands
- accum  input  1  sampled with start: 1 = add onto existing out, 0 = clear out first
- a_wren  input  ROWS  per-row write enable for A FIFO r
- a_data  input  DATA_WIDTH  A element written to every enabled row
- b_wren  input  1  write enable for the B FIFO
- b_data  input  DATA_WIDTH  B element
- ready  output  1  idle and all ROWS+1 FIFOs hold exactly COLS entries
- busy  output  1  run in progress
- done  output  1  one-cycle pulse when results are final
- err  output  1  sticky error flag
- out  output  ROWS*ACC_WIDTH  row r result at [r*ACC_WIDTH +: ACC_WIDTH]

## Operation
- FIFOs are first-word-fall-through, depth COLS. Element k is the k-th word written.
- States:
  - IDLE -> RUN on start && ready && !clr.
  - RUN -> IDLE after the final cycle, with done=1 in the following cycle.
  - clr in any state -> IDLE.
- On accept: latch signed_mode/accum. If accum=0, all out lanes load 0 at the accept edge.
- RUN counter cnt = 0 .. ROWS+COLS-2.
  - B FIFO pops on cnt 0..COLS-1 into a skew shift chain; lane r sees B[k] delayed r cycles.
  - Lane r pops A FIFO r and accumulates A[r][cnt-r]*B[cnt-r] when r <= cnt <= r+COLS-1.
- Arithmetic:
  - Operands are zero-extended (signed_mode=0) or sign-extended (signed_mode=1).
  - Full 2*DATA_WIDTH product, extended to ACC_WIDTH.
  - Sum wraps modulo 2^ACC_WIDTH; no saturation.
- Writes:
  - Applied only in IDLE. A write to a full FIFO is dropped.
  - Any write during busy, or to a full FIFO, sets err. Dropped writes leave FIFO contents unchanged.
- start when !ready or busy: ignored, no err.
- clr has priority over everything that cycle:
  - FIFOs are emptied and out is zeroed.
  - err is cleared, and the state is forced to IDLE.
  - done is not pulsed for an aborted run.
- out holds its value from run end until the next accepted start (accum=0) or clr.

## Timing
- Reset: state IDLE, FIFOs empty, out=0, ready=0, busy=0, done=0, err=0.
- Start sampled high with ready at edge T:
  - busy=1 for cycles T+1 .. T+ROWS+COLS-1.
  - done=1 and busy=0 in cycle T+ROWS+COLS.
  - ready=0 from T+1 (FIFOs drain).
- Total latency, start accept to done, is ROWS+COLS cycles. Back-to-back runs need COLS reload writes per FIFO.
- out lane r is final after cnt=r+COLS-1. All lanes are valid when done=1.
- ready and err are registered, updated the cycle after the causing event.
- A write and a start in the same IDLE cycle: the write lands, and start uses ready as it was before the write.

## Test plan
- Unsigned 8x8 load with A[r][k]=r+1 and B[k]=k+1, then start:
  - busy for 15 cycles, then done pulse 16 cycles after accept.
  - out[r]=36*(r+1).
- Repeat the same load with accum=1 -> out[r]=72*(r+1).
- signed_mode=1 with all A=0xFF (-1) and all B=0x02 -> out[r]=0x7FFF0 (-16 in 19 bits).
- All operands 0xFF, unsigned -> out[r]=520200 (0x7F008), no wrap.
- Row 3 holds only 7 entries:
  - start -> ignored, busy=0, ready=0.
  - Write the 8th entry -> ready=1 next cycle; start is then accepted.
- Ninth write to a full row -> err=1 and FIFO contents intact.
- clr at RUN cycle 5:
  - busy=0 the next cycle.
  - No done pulse, out=0, ready=0, err=0.
